ds1302_xfer: RTL

//  Generic DS1302 3-wire transfer engine: single-byte or burst read/write of clock/RAM registers.

---
 rtl/ds1302_xfer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ds1302_xfer.sv
// ds1302_xfer: DS1302 3-wire transfer engine (command byte, then single or burst data bytes).
// Burst/len handling is built only when DS1302_BURST_EN is defined; otherwise every transfer is one byte.
module ds1302_xfer #(
  parameter int CLK_DIV   = 50,
  parameter int MAX_BYTES = 31,
  localparam int LEN_W    = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic             ram_sel,
  input  logic [4:0]       addr,
  input  logic             burst,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wdata,
  output logic             wready,
  output logic [7:0]       rdata,
  output logic             rvalid,
  output logic             busy,
  output logic             done,
  output logic             ce,
  output logic             sclk,
  output logic             io_oe,
  output logic             io_out,
  input  logic             io_in
);

  // state   | meaning
  // IDLE    | waiting for start, all pins low
  // SETUP   | ce high, cmd bit0 on io, sclk low for one half-period
  // CMD     | shifting the 8 command bits out
  // WDATA   | shifting write bytes out, wready per byte
  // RDATA   | io released, sampling io_in on sclk rise
  // HOLD    | sclk low for one half-period before ce drops
  // RECOVER | ce low for 2*CLK_DIV cycles, done on the last one
  typedef enum logic [2:0] {
    IDLE, SETUP, CMD, WDATA, RDATA, HOLD, RECOVER
  } state_t;

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] HALF_TC = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] REC_TC  = DIV_W'(2 * CLK_DIV - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic [7:0]       shift_q, shift_d;
  logic             rw_q, rw_d;
  logic             ce_q, ce_d;
  logic             sclk_q, sclk_d;
  logic             oe_q, oe_d;
  logic             io_out_q, io_out_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic             burst_eff;
  logic [LEN_W-1:0] len_eff;
  logic [7:0]       cmd;
  logic             tc;

`ifdef DS1302_BURST_EN
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BYTES);
  always_comb begin
    burst_eff = burst;
    if (len == '0)        len_eff = LEN_W'(1);
    else if (len > MAX_L) len_eff = MAX_L;
    else                  len_eff = len;
  end
`else
  logic unused_burst;
  assign unused_burst = ^{burst, len};
  assign burst_eff    = 1'b0;
  assign len_eff      = LEN_W'(1);
`endif

  assign cmd = {1'b1, ram_sel, (burst_eff ? 5'h1F : addr), rw};
  assign tc  = (div_q == '0);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    left_d   = left_q;
    shift_d  = shift_q;
    rw_d     = rw_q;
    ce_d     = ce_q;
    sclk_d   = sclk_q;
    oe_d     = oe_q;
    io_out_d = io_out_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wready   = 1'b0;
    done     = 1'b0;
    if (div_q != '0) div_d = div_q - DIV_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETUP;
          div_d    = HALF_TC;
          rw_d     = rw;
          left_d   = len_eff - LEN_W'(1);
          shift_d  = cmd;
          ce_d     = 1'b1;
          oe_d     = 1'b1;
          io_out_d = cmd[0];
          sclk_d   = 1'b0;
        end
      end
      SETUP: begin
        if (tc) begin
          state_d = CMD;
          div_d   = HALF_TC;
          bit_d   = 3'd7;
        end
      end
      CMD, WDATA, RDATA: begin
        if (tc) begin
          div_d  = HALF_TC;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // rising edge: read bits are captured here, write bits are already stable
            if (state_q == RDATA) begin
              shift_d = {io_in, shift_q[7:1]};
              if (bit_q == 3'd0) begin
                rdata_d  = {io_in, shift_q[7:1]};
                rvalid_d = 1'b1;
              end
            end
          end else if (bit_q != 3'd0) begin
            bit_d = bit_q - 3'd1;
            if (state_q != RDATA) begin
              shift_d  = {1'b0, shift_q[7:1]};
              io_out_d = shift_q[1];
            end
          end else begin
            bit_d = 3'd7;
            if (state_q == CMD) begin
              if (rw_q) begin
                state_d  = RDATA;
                oe_d     = 1'b0;
                io_out_d = 1'b0;
              end else begin
                state_d  = WDATA;
                wready   = 1'b1;
                shift_d  = wdata;
                io_out_d = wdata[0];
              end
            end else if (left_q == '0) begin
              state_d = HOLD;
            end else begin
              left_d = left_q - LEN_W'(1);
              if (state_q == WDATA) begin
                wready   = 1'b1;
                shift_d  = wdata;
                io_out_d = wdata[0];
              end
            end
          end
        end
      end
      HOLD: begin
        if (tc) begin
          state_d  = RECOVER;
          div_d    = REC_TC;
          ce_d     = 1'b0;
          oe_d     = 1'b0;
          io_out_d = 1'b0;
        end
      end
      RECOVER: begin
        if (tc) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      left_q   <= '0;
      shift_q  <= '0;
      rw_q     <= 1'b0;
      ce_q     <= 1'b0;
      sclk_q   <= 1'b0;
      oe_q     <= 1'b0;
      io_out_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      left_q   <= left_d;
      shift_q  <= shift_d;
      rw_q     <= rw_d;
      ce_q     <= ce_d;
      sclk_q   <= sclk_d;
      oe_q     <= oe_d;
      io_out_q <= io_out_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign ce     = ce_q;
  assign sclk   = sclk_q;
  assign io_oe  = oe_q;
  assign io_out = io_out_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule
